// File: rtl/wb_pkg.sv
// Shared definitions for the writeback unit: data width default, register
// address width and the queued result record {rd, data}.
package wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W       = 5;

  typedef struct packed {
    logic [RD_W-1:0]       rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Write-request queue for the writeback unit.
// Ports: clock/reset (async, active-high), push/push_data enqueue at the tail,
// pop dequeues the head, head shows the current head entry, full/empty/count
// report occupancy. Push while full and pop while empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU and load results into a write queue, drains
// one entry per cycle into a registered register-file write port, and keeps a
// busy scoreboard of destinations reserved at issue and not yet written.
// Ports: clock, reset (async, active-high); aluValid/aluRd/aluData/aluReady and
// memValid/memRd/memData/memReady result handshakes; issueValid/issueRd
// reservations; rWrite/rsWrite/dataWrite register-file write; busyMask;
// pendingCount queue occupancy.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     aluValid,
  input  logic [RD_W-1:0]          aluRd,
  input  logic [DATA_W-1:0]        aluData,
  output logic                     aluReady,
  input  logic                     memValid,
  input  logic [RD_W-1:0]          memRd,
  input  logic [DATA_W-1:0]        memData,
  output logic                     memReady,
  input  logic                     issueValid,
  input  logic [RD_W-1:0]          issueRd,
  output logic                     rWrite,
  output logic [RD_W-1:0]          rsWrite,
  output logic [DATA_W-1:0]        dataWrite,
  output logic [31:0]              busyMask,
  output logic [$clog2(DEPTH):0]   pendingCount
);

  localparam int EW = RD_W + DATA_W;

  logic              full;
  logic              empty;
  logic              can_take;
  logic              prefer_mem;
  logic              mem_fire;
  logic              alu_fire;
  logic              push;
  logic              pop;
  logic [RD_W-1:0]   acc_rd;
  logic [DATA_W-1:0] acc_data;
  logic [EW-1:0]     head;
  logic [RD_W-1:0]   head_rd;
  logic [DATA_W-1:0] head_data;
  logic [31:0]       busy_next;

  // prefer_mem names the winner of the next contended cycle.
  assign can_take = !reset && !full;
  assign memReady = can_take && (!aluValid || prefer_mem);
  assign aluReady = can_take && (!memValid || !prefer_mem);
  assign mem_fire = memValid && memReady;
  assign alu_fire = aluValid && aluReady;

  assign acc_rd   = mem_fire ? memRd   : aluRd;
  assign acc_data = mem_fire ? memData : aluData;
  // Results aimed at x0 complete the handshake but are dropped here.
  assign push     = (mem_fire || alu_fire) && (acc_rd != '0);
  assign pop      = !empty;

  assign head_rd   = head[EW-1 -: RD_W];
  assign head_data = head[DATA_W-1:0];

  wb_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ({acc_rd, acc_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (pendingCount)
  );

  // Set is applied after clear so a same-edge re-issue keeps the bit.
  always_comb begin
    busy_next = busyMask;
    if (pop) busy_next[head_rd] = 1'b0;
    if (issueValid && (issueRd != '0)) busy_next[issueRd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rWrite     <= 1'b0;
      rsWrite    <= '0;
      dataWrite  <= '0;
      busyMask   <= '0;
      prefer_mem <= 1'b1;
    end else begin
      if (memValid && aluValid && can_take) prefer_mem <= !prefer_mem;
      rWrite   <= pop;
      if (pop) begin
        rsWrite   <= head_rd;
        dataWrite <= head_data;
      end
      busyMask <= busy_next;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH  = 2;
  localparam int DATA_W = 32;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              aluValid = 1'b0, memValid = 1'b0, issueValid = 1'b0;
  logic [4:0]        aluRd = '0, memRd = '0, issueRd = '0;
  logic [DATA_W-1:0] aluData = '0, memData = '0;
  logic              aluReady, memReady, rWrite;
  logic [4:0]        rsWrite;
  logic [DATA_W-1:0] dataWrite;
  logic [31:0]       busyMask;
  logic [CW-1:0]     pendingCount;

  writeback_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .aluValid(aluValid), .aluRd(aluRd), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memRd(memRd), .memData(memData), .memReady(memReady),
    .issueValid(issueValid), .issueRd(issueRd),
    .rWrite(rWrite), .rsWrite(rsWrite), .dataWrite(dataWrite),
    .busyMask(busyMask), .pendingCount(pendingCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          edge_no;
  } exp_t;

  exp_t        exp_q[$];
  wb_entry_t   mq[$];
  logic [31:0] busy_m = '0;
  bit          last_mem_won = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    edge_n++;
  endtask

  // Scoreboard monitor: every write pulse must match the oldest accepted result.
  always @(negedge clock) begin
    if (rWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: rd %0d data %0h with nothing pending", rsWrite, dataWrite);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("write_rd", 64'(rsWrite), 64'(e.rd));
        check("write_data", 64'(dataWrite), 64'(e.data));
        check("write_latency", 64'(edge_n), 64'(e.edge_no + 1));
      end
    end
  end

  task automatic cycle(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input bit iv, input logic [4:0] ird);
    bit        full, em_r, ea_r, mem_acc, alu_acc;
    wb_entry_t e;
    @(negedge clock);
    check("pending", 64'(pendingCount), 64'(mq.size()));
    check("busy", 64'(busyMask), 64'(busy_m));
    aluValid = av; aluRd = ard; aluData = ad;
    memValid = mv; memRd = mrd; memData = md;
    issueValid = iv; issueRd = ird;
    #1;
    full = (mq.size() >= DEPTH);
    if (av && mv) begin
      em_r = !full && !last_mem_won;
      ea_r = !full && last_mem_won;
    end else begin
      em_r = !full;
      ea_r = !full;
    end
    if (mv) check("mem_ready", 64'(memReady), 64'(em_r));
    if (av) check("alu_ready", 64'(aluReady), 64'(ea_r));
    mem_acc = mv && em_r;
    alu_acc = av && ea_r;
    tick();
    if (av && mv && !full) last_mem_won = mem_acc;
    if (mq.size() > 0) begin
      e = mq.pop_front();
      busy_m[e.rd] = 1'b0;
    end
    if (mem_acc && mrd != 0) begin
      mq.push_back('{rd: mrd, data: md});
      exp_q.push_back('{rd: mrd, data: md, edge_no: edge_n});
    end
    if (alu_acc && ard != 0) begin
      mq.push_back('{rd: ard, data: ad});
      exp_q.push_back('{rd: ard, data: ad, edge_no: edge_n});
    end
    if (iv && ird != 0) busy_m[ird] = 1'b1;
    busy_m[0] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    aluValid = 1; aluRd = 5'd9; memValid = 1; memRd = 5'd10; issueValid = 0;
    reset = 1'b1;
    #1;
    check("rst_rWrite", 64'(rWrite), 0);
    check("rst_rsWrite", 64'(rsWrite), 0);
    check("rst_dataWrite", 64'(dataWrite), 0);
    check("rst_busy", 64'(busyMask), 0);
    check("rst_pending", 64'(pendingCount), 0);
    check("rst_alu_ready", 64'(aluReady), 0);
    check("rst_mem_ready", 64'(memReady), 0);
    mq.delete();
    exp_q.delete();
    busy_m = '0;
    last_mem_won = 1'b0;
    tick();
    tick();
    @(negedge clock);
    aluValid = 0; memValid = 0;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single ALU result: write visible after the next edge, gone after one more.
    cycle(1, 5'd5, 32'h0000_00AA, 0, 0, 0, 0, 0);
    idle(3);

    // Contention: memory wins first, then ALU.
    cycle(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0, 0);
    cycle(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0, 0);
    cycle(0, 0, 0, 1, 5'd3, 32'h11, 0, 0);
    idle(3);

    // Back-to-back stream, all must drain in order.
    for (int i = 1; i <= 5; i++) cycle(1, 5'(i + 10), 32'h1000 + 32'(i), 0, 0, 0, 0, 0);
    idle(3);

    // Result to x0 is swallowed.
    cycle(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    idle(2);

    // Scoreboard: issue x7, write x7, re-issue on the pop edge keeps the bit.
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    cycle(1, 5'd7, 32'h77, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd7);
    idle(2);
    cycle(1, 5'd7, 32'h78, 0, 0, 0, 0, 0);
    idle(2);
    cycle(0, 0, 0, 0, 0, 0, 1, 5'd0);

    // Reset while results are in flight: nothing may be written afterwards.
    cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 1, 5'd12);
    cycle(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 1, 5'd13);
    cycle(1, 5'd6, 32'hC3, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)));
      if (i == 200) do_reset();
    end
    idle(4);
    check("drain_left", 64'(exp_q.size()), 0);
    check("drain_pending", 64'(pendingCount), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
